// File: rtl/bf_ctl_pkg.sv
// ---------------------------------------------------------------------------
// bf_ctl_pkg
// Shared types and helpers for the butterfly load/compute sequencer.
//   bf_state_t      : sequencer FSM states (IDLE, LOAD, COMP, OUT)
//   RADIX_LOG2_MAX  : largest supported log2 radix (radix-8)
//   onehot_ld()     : turns a sample phase into a one-hot load strobe vector
// ---------------------------------------------------------------------------
package bf_ctl_pkg;

  localparam int RADIX_LOG2_MAX = 3;
  localparam int RADIX_MAX      = 1 << RADIX_LOG2_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    COMP = 2'd2,
    OUT  = 2'd3
  } bf_state_t;

  // Widest possible strobe vector; callers truncate to their own radix.
  function automatic logic [RADIX_MAX-1:0] onehot_ld(input logic [RADIX_LOG2_MAX-1:0] phase);
    onehot_ld = RADIX_MAX'(1) << phase;
  endfunction

endpackage

// File: rtl/bf_phase_cnt.sv
// ---------------------------------------------------------------------------
// bf_phase_cnt
// Wrapping sample-phase counter for one butterfly group.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   inc      : advance the phase by one (one accepted sample)
//   limit    : highest phase of the group; the counter wraps to 0 after it
//   phase    : current phase (index of the next sample to load)
//   last     : phase equals limit, i.e. the next accept completes the group
// ---------------------------------------------------------------------------
module bf_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] phase,
  output logic         last
);

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;

  assign last  = (phase_q == limit);
  assign phase = phase_q;

  // Next phase: hold unless a sample is taken, wrap after the group's last one.
  always_comb begin
    phase_d = phase_q;
    if (inc) begin
      phase_d = last ? '0 : phase_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/bf_seq_ctl.sv
// ---------------------------------------------------------------------------
// bf_seq_ctl
// Load/compute sequencer for a radix-2^RADIX_LOG2 butterfly unit. Collects
// RADIX samples per group (valid/ready), strobes one sample register per
// accepted sample, fires the butterfly for one cycle, then holds the result
// until the consumer takes it. A frame is frame_len groups (0 = 2**GRP_W).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a frame (only looked at while idle)
//   frame_len     : groups per frame, captured with start
//   r2_mode       : (only with BF_SEQ_CTL_MODE_SEL_EN) captured with start;
//                   high forces two samples per group
//   in_valid/in_ready   : sample input handshake
//   ld            : one-hot sample register load strobe, only on an accept
//   by_pass       : low for the single butterfly compute cycle
//   out_valid/out_ready : result handshake
//   grp_cnt       : index of the group being loaded
//   busy          : frame in progress
//   frame_done    : one-cycle pulse after the last result is taken
// Optional feature macro: BF_SEQ_CTL_MODE_SEL_EN
// ---------------------------------------------------------------------------
module bf_seq_ctl
  import bf_ctl_pkg::*;
#(
  parameter int RADIX_LOG2 = 2,
  parameter int GRP_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [GRP_W-1:0]           frame_len,
`ifdef BF_SEQ_CTL_MODE_SEL_EN
  input  logic                       r2_mode,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [(1<<RADIX_LOG2)-1:0] ld,
  output logic                       by_pass,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [GRP_W-1:0]           grp_cnt,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int RADIX = 1 << RADIX_LOG2;
  localparam int PW    = RADIX_LOG2;

  bf_state_t        state_q, state_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [GRP_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic [PW-1:0]    phase;
  logic [PW-1:0]    limit;
  logic             phase_last;
  logic             accept;
  logic             last_grp;

  assign accept = in_valid & in_ready;

  // len_q == 0 wraps to all-ones here, which is exactly the last index of a
  // full 2**GRP_W group frame.
  assign last_grp = (grp_q == len_q - GRP_W'(1));

`ifdef BF_SEQ_CTL_MODE_SEL_EN
  logic r2_q, r2_d;
  assign limit = r2_q ? PW'(1) : PW'(RADIX - 1);
`else
  assign limit = PW'(RADIX - 1);
`endif

  bf_phase_cnt #(
    .W(PW)
  ) u_phase (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .limit(limit),
    .phase(phase),
    .last (phase_last)
  );

  // Strobe is derived combinationally from the accept so the sample register
  // captures the same cycle the handshake completes.
  assign ld = accept ? RADIX'(onehot_ld(RADIX_LOG2_MAX'(phase))) : '0;

  assign busy       = (state_q != IDLE);
  assign grp_cnt    = grp_q;
  assign frame_done = done_q;

  // Next-state and handshake outputs. In OUT the next group's sample 0 may be
  // taken in the same cycle as the result handshake, but never on the last
  // group since the frame is ending.
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    len_d     = len_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    by_pass   = 1'b1;
    out_valid = 1'b0;
`ifdef BF_SEQ_CTL_MODE_SEL_EN
    r2_d      = r2_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          grp_d   = '0;
          len_d   = frame_len;
`ifdef BF_SEQ_CTL_MODE_SEL_EN
          r2_d    = r2_mode;
`endif
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (accept && phase_last) begin
          state_d = COMP;
        end
      end
      COMP: begin
        by_pass = 1'b0;
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~last_grp;
        if (out_ready) begin
          if (last_grp) begin
            state_d = IDLE;
            done_d  = 1'b1;
            grp_d   = '0;
          end else begin
            state_d = LOAD;
            grp_d   = grp_q + GRP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
`ifdef BF_SEQ_CTL_MODE_SEL_EN
      r2_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      len_q   <= len_d;
      done_q  <= done_d;
`ifdef BF_SEQ_CTL_MODE_SEL_EN
      r2_q    <= r2_d;
`endif
    end
  end

endmodule
